// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED PWM controller for the iCE40 SB_RGBA_DRV PWM inputs.
// Each channel runs OFF / STATIC / BLINK / BREATHE; settings take effect only at PWM period boundaries.
module rgb_pwm_ctrl #(
    parameter int NCH             = 3,
    parameter int PWM_BITS        = 8,
    parameter int PRESCALE        = 188,
    parameter int BLINK_PERIODS   = 250,
    parameter int BREATHE_PERIODS = 2,
    localparam int CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [NCH-1:0]      pwm,
    output logic                period_end
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam int BRE_W = (BREATHE_PERIODS > 1) ? $clog2(BREATHE_PERIODS) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BRE_W-1:0]    bre_q, bre_d;
    logic                blink_ph_q, blink_ph_d;
    logic                tick;
    logic                blk_wrap;
    logic                step;

    assign tick       = (pre_q == PRE_W'(PRESCALE - 1));
    assign period_end = tick && (pcnt_q == '1);
    assign blk_wrap   = (blk_q == BLK_W'(BLINK_PERIODS - 1));
    assign step       = period_end && (bre_q == BRE_W'(BREATHE_PERIODS - 1));

    always_comb begin
        pre_d      = tick ? '0 : pre_q + 1'b1;
        pcnt_d     = tick ? pcnt_q + 1'b1 : pcnt_q;
        blk_d      = blk_q;
        bre_d      = bre_q;
        blink_ph_d = blink_ph_q;
        if (period_end) begin
            blk_d      = blk_wrap ? '0 : blk_q + 1'b1;
            bre_d      = step ? '0 : bre_q + 1'b1;
            blink_ph_d = blink_ph_q ^ blk_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            pcnt_q     <= '0;
            blk_q      <= '0;
            bre_q      <= '0;
            blink_ph_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            pcnt_q     <= pcnt_d;
            blk_q      <= blk_d;
            bre_q      <= bre_d;
            blink_ph_q <= blink_ph_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        mode_e               sh_mode_q, act_mode_q;
        logic [PWM_BITS-1:0] sh_duty_q, act_duty_q;
        logic [PWM_BITS-1:0] level_q, level_d;
        logic                dir_q, dir_d;
        logic [PWM_BITS-1:0] eff;
        logic                pwm_q;
        logic                wr_hit;

        // Out-of-range channel numbers never match any gi, so they are dropped here.
        assign wr_hit = cfg_we && (cfg_ch == CHW'(gi));

        always_comb begin
            level_d = level_q;
            dir_d   = dir_q;
            if (period_end && sh_mode_q == MODE_BREATHE && act_mode_q != MODE_BREATHE) begin
                level_d = '0;
                dir_d   = 1'b1;
            end else if (step && act_mode_q == MODE_BREATHE) begin
                if (dir_q) begin
                    if (level_q < act_duty_q) level_d = level_q + 1'b1;
                    else                      dir_d   = 1'b0;
                end else begin
                    if (level_q != '0) level_d = level_q - 1'b1;
                    else               dir_d   = 1'b1;
                end
            end
        end

        always_comb begin
            eff = '0;
            case (act_mode_q)
                MODE_STATIC:  eff = act_duty_q;
                MODE_BLINK:   eff = blink_ph_q ? act_duty_q : '0;
                MODE_BREATHE: eff = level_q;
                default:      eff = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sh_mode_q  <= MODE_OFF;
                sh_duty_q  <= '0;
                act_mode_q <= MODE_OFF;
                act_duty_q <= '0;
                level_q    <= '0;
                dir_q      <= 1'b1;
                pwm_q      <= 1'b0;
            end else begin
                if (wr_hit) begin
                    sh_mode_q <= mode_e'(cfg_mode);
                    sh_duty_q <= cfg_duty;
                end
                // Loading from the pre-write shadow makes a coincident write land one period later.
                if (period_end) begin
                    act_mode_q <= sh_mode_q;
                    act_duty_q <= sh_duty_q;
                end
                level_q <= level_d;
                dir_q   <= dir_d;
                pwm_q   <= (pcnt_q < eff);
            end
        end

        assign pwm[gi] = pwm_q;
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: per-period pulse widths are collected and checked against a queue of expectations.
// A second, default-parameter instance is used only for the period length check.
module tb_rgb_pwm_ctrl;
    localparam int PB = 4;
    localparam int M_OFF = 0, M_STATIC = 1, M_BLINK = 2, M_BREATHE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PB-1:0] cfg_duty = '0;
    logic [2:0]    pwm;
    logic          period_end;

    logic          rst_b = 1'b1;
    logic          d_we = 1'b0;
    logic [1:0]    d_ch = '0;
    logic [1:0]    d_mode = '0;
    logic [7:0]    d_duty = '0;
    logic [2:0]    d_pwm;
    logic          d_pe;

    always #5 clk = ~clk;

    rgb_pwm_ctrl #(
        .NCH(3), .PWM_BITS(PB), .PRESCALE(1), .BLINK_PERIODS(3), .BREATHE_PERIODS(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .pwm(pwm), .period_end(period_end)
    );

    rgb_pwm_ctrl dut_def (
        .clk(clk), .rst(rst_b), .cfg_we(d_we), .cfg_ch(d_ch), .cfg_mode(d_mode),
        .cfg_duty(d_duty), .pwm(d_pwm), .period_end(d_pe)
    );

    typedef struct {
        int w0;
        int w1;
        int w2;
    } wid_t;

    wid_t got_q[$];
    wid_t exp_q[$];
    int   acc0 = 0, acc1 = 0, acc2 = 0;
    logic pe_prev = 1'b0;
    int   done_cnt = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    // The pwm sample one cycle after period_end is the last one of that period (registered output).
    always @(negedge clk) begin
        if (rst) begin
            acc0 <= 0; acc1 <= 0; acc2 <= 0;
            pe_prev  <= 1'b0;
            done_cnt <= 0;
        end else begin
            if (pe_prev) begin
                got_q.push_back('{w0: acc0 + int'(pwm[0]), w1: acc1 + int'(pwm[1]), w2: acc2 + int'(pwm[2])});
                acc0 <= 0; acc1 <= 0; acc2 <= 0;
                done_cnt <= done_cnt + 1;
            end else begin
                acc0 <= acc0 + int'(pwm[0]);
                acc1 <= acc1 + int'(pwm[1]);
                acc2 <= acc2 + int'(pwm[2]);
            end
            pe_prev <= period_end;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic ex(input int a, input int b, input int c);
        exp_q.push_back('{w0: a, w1: b, w2: c});
    endtask

    task automatic ckp(input string tag);
        int   t = 0;
        wid_t g, e;
        e = '{w0: -1, w1: -1, w2: -1};
        do begin
            @(posedge clk);
            t++;
        end while (got_q.size() == 0 && t < 100);
        n_cmp++;
        assert (got_q.size() > 0) else begin
            n_mis++;
            $error("FAIL %s: observed no period end, expected one within 100 cycles", tag);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk({tag, "/ch0"}, g.w0, e.w0);
            chk({tag, "/ch1"}, g.w1, e.w1);
            chk({tag, "/ch2"}, g.w2, e.w2);
            $display("period %0d %s: widths %0d %0d %0d", done_cnt, tag, g.w0, g.w1, g.w2);
        end
    endtask

    task automatic sync_period();
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (got_q.size() == 0 && t < 100);
        n_cmp++;
        assert (got_q.size() > 0) else begin
            n_mis++;
            $error("FAIL sync: observed no period end, expected one within 100 cycles");
        end
        got_q.delete();
    endtask

    task automatic wr(input int ch, input int mode, input int duty);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = PB'(duty);
        @(negedge clk);
        cfg_we   = 1'b0;
        $display("write ch=%0d mode=%0d duty=%0d", ch, mode, duty);
    endtask

    function automatic int blink_w(input int k);
        return (((k - 1) / 3) % 2 == 1) ? 8 : 0;
    endfunction

    initial begin
        int n;
        int k;

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_pe", int'(period_end), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_pwm", int'(pwm), 0);

        // Static duty
        sync_period();
        wr(0, M_STATIC, 5);
        wr(1, M_STATIC, 0);
        wr(2, M_STATIC, 15);
        ex(0, 0, 0);
        ex(5, 0, 15);
        ex(5, 0, 15);
        for (int i = 0; i < 3; i++) ckp("static");

        // Glitch-free duty change mid-period
        repeat (5) @(negedge clk);
        wr(0, M_STATIC, 12);
        ex(5, 0, 15);
        ex(12, 0, 15);
        ckp("upd_cur");
        ckp("upd_next");

        // Write coinciding with period_end lands one period later
        n = 0;
        while (!period_end && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pe_found", int'(period_end), 1);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'(M_STATIC); cfg_duty = PB'(3);
        @(negedge clk);
        cfg_we = 1'b0;
        $display("write ch=0 mode=1 duty=3 on period_end");
        ex(12, 0, 15);
        ex(12, 0, 15);
        ex(3, 0, 15);
        for (int i = 0; i < 3; i++) ckp("pe_write");

        // Blink, phase from the shared counter running since reset
        k = done_cnt;
        repeat (4) @(negedge clk);
        wr(0, M_BLINK, 8);
        ex(3, 0, 15);
        for (int j = 2; j <= 10; j++) ex(blink_w(k + j), 0, 15);
        for (int i = 0; i < 10; i++) ckp("blink");

        // Breathe with peak 3
        k = done_cnt;
        repeat (4) @(negedge clk);
        wr(0, M_BREATHE, 3);
        ex(blink_w(k + 1), 0, 15);
        ex(0, 0, 15); ex(1, 0, 15); ex(2, 0, 15); ex(3, 0, 15); ex(3, 0, 15);
        ex(2, 0, 15); ex(1, 0, 15); ex(0, 0, 15); ex(0, 0, 15); ex(1, 0, 15);
        for (int i = 0; i < 11; i++) ckp("breathe");

        // STATIC 7 then back to BREATHE restarts the ramp
        repeat (4) @(negedge clk);
        wr(0, M_STATIC, 7);
        ex(2, 0, 15);
        ex(7, 0, 15);
        ckp("br_to_static");
        ckp("static7");
        repeat (4) @(negedge clk);
        wr(0, M_BREATHE, 3);
        ex(7, 0, 15);
        ex(0, 0, 15);
        ex(1, 0, 15);
        for (int i = 0; i < 3; i++) ckp("br_restart");

        // Out-of-range channel write is ignored
        repeat (4) @(negedge clk);
        wr(3, M_STATIC, 9);
        ex(2, 0, 15);
        ex(3, 0, 15);
        ckp("oob_cur");
        ckp("oob_next");

        // Reset mid-breathe
        n = 0;
        while (pwm == 3'b000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pwm_active_before_rst", int'(pwm != 3'b000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_pe", int'(period_end), 0);
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        rst = 1'b0;
        n = 1;
        while (!period_end && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_pe_after_rst", n, 16);
        ex(0, 0, 0);
        ckp("after_rst");

        // Blink phase, breathe state and modes all restart from reset values
        k = done_cnt;
        wr(0, M_BLINK, 8);
        wr(1, M_BREATHE, 2);
        wr(2, M_STATIC, 1);
        ex(0, 0, 0);
        ex(blink_w(k + 2), 0, 1);
        ex(blink_w(k + 3), 1, 1);
        ex(blink_w(k + 4), 2, 1);
        for (int i = 0; i < 4; i++) ckp("post_rst_modes");

        // Default parameters: period length
        @(negedge clk);
        rst_b = 1'b0;
        n = 1;
        while (!d_pe && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("default_period", n, 48128);
        chk("default_pwm_off", int'(d_pwm), 0);
        @(negedge clk);
        chk("default_pe_pulse", int'(d_pe), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_ctrl.md
# rgb_pwm_ctrl

Parametrised multi-channel LED PWM controller that drives the `RGBnPWM` inputs of the iCE40 `SB_RGBA_DRV` hard driver. Replaces the fixed on/off/blink wiring with per-channel modes: off, static duty, blink and breathe. Duty and mode are updated glitch-free at PWM period boundaries. The block sits between user/control logic and the LED driver instance in `top`.

## Interface
- `NCH`, 3, number of LED channels.
- `PWM_BITS`, 8, PWM counter and duty width; period is 2^PWM_BITS ticks.
- `PRESCALE`, 188, clk cycles per PWM tick (≥1); 48 MHz / 188 / 256 ≈ 1 kHz PWM.
- `BLINK_PERIODS`, 250, PWM periods per blink half-phase (≥1).
- `BREATHE_PERIODS`, 2, PWM periods per breathe level step (≥1).

- `clk`  in  1  system clock (post-`SB_GB` 48 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  config write strobe; always accepted, no back-pressure.
- `cfg_ch`  in  $clog2(NCH) (min 1)  target channel; values ≥ NCH are ignored.
- `cfg_mode`  in  2  00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE.
- `cfg_duty`  in  PWM_BITS  duty, or peak level for BREATHE.
- `pwm`  out  NCH  per-channel PWM, registered; connects to the driver PWM inputs.
- `period_end`  out  1  one-cycle pulse on the last clk of each PWM period.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1. `tick` is asserted when `pre == PRESCALE-1`.
- PWM counter `pcnt` (PWM_BITS wide) increments on `tick` and wraps from all-ones to 0.
- `period_end` = `tick && pcnt == all-ones`.
- Each channel has shadow registers (mode, duty) written on `cfg_we`, and active registers loaded from shadow on `period_end`.
  - Same-cycle `cfg_we` and `period_end`: active takes the old shadow; the new value becomes active at the next `period_end`.
- Blink phase: a shared counter counts `period_end` pulses 0..BLINK_PERIODS-1. On wrap, `blink_ph` toggles.
- Breathe step: a shared counter counts `period_end` pulses 0..BREATHE_PERIODS-1. On wrap, `step` pulses for one cycle, coincident with `period_end`.
- Per-channel breathe state: `level` (PWM_BITS) and `dir` (1 = up).
  - When active mode is (re)loaded as BREATHE from a non-BREATHE mode: `level` ← 0, `dir` ← 1.
  - On `step` in BREATHE, direction up: if `level < duty` then `level` +1, else `dir` ← 0.
  - On `step` in BREATHE, direction down: if `level > 0` then `level` −1, else `dir` ← 1.
  - `duty` = 0 holds `level` at 0.
  - If `duty` is lowered below `level` while direction is up, the next step flips `dir` to down and the ramp descends normally.
- Effective duty `eff`:
  - OFF: 0.
  - STATIC: `duty`.
  - BLINK: `blink_ph ? duty : 0`.
  - BREATHE: `level`.
- `pwm[i]` ← (`pcnt < eff[i]`).
  - `eff` = 0: output is constantly low.
  - `eff` = all-ones: high for 2^PWM_BITS − 1 of 2^PWM_BITS ticks. Full-on is never produced; this is intentional, since current limiting is done in the driver.
- Arithmetic is unsigned. `level` never wraps.

## Timing
- Reset state: `pwm` = 0, `period_end` = 0, `pre` = `pcnt` = 0, both shared counters = 0, `blink_ph` = 0, all modes OFF, all duties 0, `level` = 0, `dir` = 1.
- `rst` mid-period aborts immediately. The first `period_end` after release occurs 2^PWM_BITS·PRESCALE cycles after the first non-reset cycle.
- `pwm` is one cycle behind the `pcnt` compare.
- Write-to-output latency: the active update happens at the first `period_end` strictly after the `cfg_we` cycle. The first changed `pwm` value appears 1 cycle after that `period_end`, i.e. the first cycle of the new period's output.
- `cfg_we` on every cycle is legal. The last write before `period_end` wins.
- A mode change applies on the period boundary. A blink phase toggle also lands on a period boundary, so no runt pulses occur.

## Test plan
1. Reset and static duty. Bench params: PRESCALE=1, PWM_BITS=4. Write ch0 STATIC duty 5; ch1 duty 0; ch2 duty 15.
   - Ch0 is high for exactly 5 of every 16 cycles.
   - Ch1 is always low.
   - Ch2 is low for exactly 1 cycle per period.
   - All outputs are 0 during and immediately after reset.
2. Glitch-free update. Change ch0 duty 5→12 mid-period.
   - The current period keeps width 5.
   - The next period has width 12.
   - A write coinciding with `period_end` takes effect one period later.
3. Blink. Params: BLINK_PERIODS=3, ch0 BLINK duty 8.
   - Output is 3 periods of 0, then 3 periods of 8/16, repeating.
   - The first high period begins exactly at a period boundary.
4. Breathe. Params: BREATHE_PERIODS=1, duty 3.
   - Per-period widths are 0,1,2,3,3,2,1,0,0,1,…
   - Switching to STATIC 7 and back to BREATHE restarts the ramp from 0.
5. Out-of-range channel and reset mid-operation. Params: NCH=3.
   - A write with `cfg_ch`=3 changes no channel.
   - Asserting `rst` mid-breathe zeroes `pwm` next cycle and returns all state to reset values.
6. Default params. Check that the `period_end` spacing is exactly 48128 cycles.
